// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the buffered UART transmitter.
//   PAR_NONE / PAR_ODD / PAR_EVEN : encodings of the 2-bit parity_type input
//                                   (3 is also treated as "none").
//   uart_state_e                  : transmitter FSM state type.
//   parity_bit()                  : parity bit for a payload, zero-extended to 9 bits.
// Optional feature macro: UART_TX_BREAK_EN adds the BRK (line break) state.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_ODD  = 2'd1;
  localparam logic [1:0] PAR_EVEN = 2'd2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
`ifdef UART_TX_BREAK_EN
    ,
    BRK    = 3'd5
`endif
  } uart_state_e;

  // Zero padding above the payload width does not change the XOR reduction.
  function automatic logic parity_bit(input logic [8:0] data, input logic [1:0] ptype);
    return (ptype == PAR_ODD) ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with wrap-around pointers. Each pointer has
// one bit more than the address, so equal addresses with differing MSBs
// mean full and identical pointers mean empty.
//   clk_i, rst_ni     : clock, asynchronous active-low reset
//   push_i/push_data_i: write request and data (ignored while full)
//   pop_i/pop_data_o  : read request (ignored while empty), head-of-queue data
//   full_o, empty_o   : status from the registered pointers
//   count_o           : number of stored entries
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       pop_data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign count_o = wr_ptr_q - rd_ptr_q;

  // full_o comes from registered pointers, so a pop in the same cycle never
  // makes room for a write into a full buffer.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  assign wr_ptr_d   = push_ok ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
  assign rd_ptr_d   = pop_ok  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
  assign pop_data_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: UART transmitter fed by a FIFO.
// Frame: start(0), DATA_BITS payload LSB first, optional parity, STOP_BITS
// stop(1); every bit lasts CLKS_PER_BIT = max(2, CLK_FREQ/BAUD) clocks.
//   clk, rst         : clock, asynchronous active-low reset
//   wr_data/wr_valid : enqueue port; wr_ready high when the FIFO is not full
//   parity_type      : 0/3 none, 1 odd, 2 even; latched when a word is popped
//   serial_out       : TX line, idle high
//   busy             : high whenever the FSM is not in IDLE
//   fifo_count       : number of buffered words
//   state_dbg        : current FSM state
//   send_break       : only with UART_TX_BREAK_EN -- hold line low while high,
//                      then for one full frame time more
// Handshake: a word is taken on every rising edge where wr_valid && wr_ready;
// wr_valid while wr_ready is low is dropped, and the source must not expect
// it to be retried.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_BITS-1:0]        wr_data,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  input  logic [1:0]                  parity_type,
`ifdef UART_TX_BREAK_EN
  input  logic                        send_break,
`endif
  output logic                        serial_out,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output uart_state_e                 state_dbg
);

  localparam int CPB_RAW    = CLK_FREQ / BAUD;
  localparam int CPB        = (CPB_RAW < 2) ? 2 : CPB_RAW;
  // Longest frame (with parity); also the minimum break length.
  localparam int FRAME_CLKS = (DATA_BITS + 2 + STOP_BITS) * CPB;
  localparam int CNT_W      = $clog2(FRAME_CLKS + 1);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS * CPB - 1);
`ifdef UART_TX_BREAK_EN
  localparam logic [CNT_W-1:0] BRK_LAST  = CNT_W'(FRAME_CLKS - 1);
`endif
  localparam logic [3:0]       IDX_LAST  = 4'(DATA_BITS - 1);

  uart_state_e          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [3:0]           bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic [1:0]           par_q, par_d;
  logic                 par_bit_q, par_bit_d;

  logic                 pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] fifo_data;
  logic                 bit_done;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk),
    .rst_ni      (rst),
    .push_i      (wr_valid),
    .push_data_i (wr_data),
    .pop_i       (pop),
    .pop_data_o  (fifo_data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign wr_ready  = !fifo_full;
  assign bit_done  = (cnt_q == BIT_LAST);
  assign state_dbg = state_q;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      data_q    <= '0;
      par_q     <= PAR_NONE;
      par_bit_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      data_q    <= data_d;
      par_q     <= par_d;
      par_bit_q <= par_bit_d;
    end
  end

  // Next-state logic. The counter restarts on every state entry and on every
  // new data bit; the payload register shifts right so bit 0 is always on air.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_W'(1);
    bit_idx_d = bit_idx_q;
    data_d    = data_q;
    par_d     = par_q;
    par_bit_d = par_bit_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
`ifdef UART_TX_BREAK_EN
        if (send_break) state_d = BRK;
        else
`endif
        if (!fifo_empty) begin
          pop       = 1'b1;
          data_d    = fifo_data;
          par_d     = parity_type;
          par_bit_d = parity_bit(9'(fifo_data), parity_type);
          state_d   = START;
        end
      end
      START: begin
        if (bit_done) begin
          state_d   = DATA;
          cnt_d     = '0;
          bit_idx_d = '0;
        end
      end
      DATA: begin
        if (bit_done) begin
          cnt_d  = '0;
          data_d = data_q >> 1;
          if (bit_idx_q == IDX_LAST) begin
            state_d = (par_q == PAR_ODD || par_q == PAR_EVEN) ? PARITY : STOP;
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
          end
        end
      end
      PARITY: begin
        if (bit_done) begin
          state_d = STOP;
          cnt_d   = '0;
        end
      end
      STOP: begin
        if (cnt_q == STOP_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
`ifdef UART_TX_BREAK_EN
      // The frame-time countdown only starts once send_break is released.
      BRK: begin
        if (send_break) begin
          cnt_d = '0;
        end else if (cnt_q == BRK_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
`endif
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs, decoded from the registered state so reset forces them at once.
  always_comb begin
    serial_out = 1'b1;
    busy       = (state_q != IDLE);
    case (state_q)
      START:  serial_out = 1'b0;
      DATA:   serial_out = data_q[0];
      PARITY: serial_out = par_bit_q;
`ifdef UART_TX_BREAK_EN
      BRK:    serial_out = 1'b0;
`endif
      default: serial_out = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
module tb_uart_tx_buffered;
  import uart_pkg::*;

  localparam int CPB = 10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT A: 8 data bits, 1 stop, depth 4 ----------------
  logic [7:0]  wd_a;
  logic        wv_a, wr_a, so_a, busy_a;
  logic [1:0]  pt_a;
  logic [2:0]  cnt_a;
  uart_state_e st_a;
  // ---------------- DUT B: 7 data bits, 2 stop, depth 16 ----------------
  logic [6:0]  wd_b;
  logic        wv_b, wr_b, so_b, busy_b;
  logic [1:0]  pt_b;
  logic [4:0]  cnt_b;
  uart_state_e st_b;
`ifdef UART_TX_BREAK_EN
  logic brk_a, brk_b;
`endif

  uart_tx_buffered #(.CLK_FREQ(50_000_000), .BAUD(5_000_000), .DATA_BITS(8),
                     .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .rst(rst), .wr_data(wd_a), .wr_valid(wv_a), .wr_ready(wr_a),
    .parity_type(pt_a),
`ifdef UART_TX_BREAK_EN
    .send_break(brk_a),
`endif
    .serial_out(so_a), .busy(busy_a), .fifo_count(cnt_a), .state_dbg(st_a));

  uart_tx_buffered #(.CLK_FREQ(50_000_000), .BAUD(5_000_000), .DATA_BITS(7),
                     .STOP_BITS(2), .FIFO_DEPTH(16)) dut_b (
    .clk(clk), .rst(rst), .wr_data(wd_b), .wr_valid(wv_b), .wr_ready(wr_b),
    .parity_type(pt_b),
`ifdef UART_TX_BREAK_EN
    .send_break(brk_b),
`endif
    .serial_out(so_b), .busy(busy_b), .fifo_count(cnt_b), .state_dbg(st_b));

  logic sel_b;
  wire  mon_line = sel_b ? so_b : so_a;
  wire  mon_busy = sel_b ? busy_b : busy_a;

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [10:0] exp_q[$];  // {parity_type, payload}

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic push(input logic [8:0] d, output int wcyc);
    @(negedge clk);
    wcyc = cyc;
    if (sel_b) begin wd_b = d[6:0]; wv_b = 1'b1; end
    else       begin wd_a = d[7:0]; wv_a = 1'b1; end
    @(negedge clk);
    wv_a = 1'b0;
    wv_b = 1'b0;
  endtask

  // Reference model: builds the expected line bits from the frame rules and
  // samples the selected line every cycle. exp_start < 0 skips start timing.
  task automatic expect_frame(input int exp_start, input int dbits, input int nstop,
                              output int t_start, output int nbits);
    logic [10:0] e;
    logic [8:0]  d;
    logic [1:0]  pt;
    int          bits[$];
    int          ones, match, busy_n;
    bit          got;
    t_start = 0;
    nbits   = 0;
    if (exp_q.size() == 0) begin
      check_val("exp_queue_empty", 0, 1);
      return;
    end
    e  = exp_q.pop_front();
    pt = e[10:9];
    d  = e[8:0];
    got = 1'b0;
    for (int w = 0; w < 3000 && !got; w++) begin
      @(negedge clk);
      if (mon_line == 1'b0) got = 1'b1;
    end
    if (!got) begin
      check_val("start_timeout", 0, 1);
      return;
    end
    t_start = cyc;
    if (exp_start >= 0) check_val("start_cycle", t_start, exp_start);
    ones = 0;
    bits.push_back(0);
    for (int i = 0; i < dbits; i++) begin
      bits.push_back(int'(d[i]));
      ones += int'(d[i]);
    end
    if (pt == 2'd1) bits.push_back((ones % 2 == 0) ? 1 : 0);  // total ones odd
    else if (pt == 2'd2) bits.push_back(ones % 2);            // total ones even
    for (int s = 0; s < nstop; s++) bits.push_back(1);
    nbits  = bits.size();
    busy_n = 0;
    for (int b = 0; b < nbits; b++) begin
      match = 0;
      for (int k = 0; k < CPB; k++) begin
        if (!(b == 0 && k == 0)) @(negedge clk);
        if (int'(mon_line) == bits[b]) match++;
        if (mon_busy) busy_n++;
      end
      check_val($sformatf("line_bit%0d_of_%02h", b, d), match, CPB);
    end
    check_val("busy_cycles", busy_n, nbits * CPB);
    @(negedge clk);
    check_val("idle_busy", int'(mon_busy), 0);
    check_val("idle_line", int'(mon_line), 1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int wcyc, ts, nb, base, low_n;
    logic [8:0] d;
    logic [1:0] pt;
    rst = 1'b0;
    wd_a = '0; wv_a = 1'b0; pt_a = 2'd0;
    wd_b = '0; wv_b = 1'b0; pt_b = 2'd0;
    sel_b = 1'b0;
`ifdef UART_TX_BREAK_EN
    brk_a = 1'b0; brk_b = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check_val("rst_serial_out", int'(so_a), 1);
    check_val("rst_busy", int'(busy_a), 0);
    check_val("rst_wr_ready", int'(wr_a), 1);
    check_val("rst_fifo_count", int'(cnt_a), 0);
    check_val("rst_serial_out_b", int'(so_b), 1);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Directed 8'hD2 with even, odd and no parity.
    for (int i = 0; i < 3; i++) begin
      pt = (i == 0) ? 2'd2 : (i == 1) ? 2'd1 : 2'd0;
      pt_a = pt;
      exp_q.push_back({pt, 9'h0D2});
      push(9'h0D2, wcyc);
      expect_frame(wcyc + 2, 8, 1, ts, nb);
      check_val("frame_bits_d2", nb, (pt == 2'd0) ? 10 : 11);
    end

    // Random words and parity; parity_type is scrambled while the frame runs.
    for (int i = 0; i < 8; i++) begin
      d  = 9'($urandom_range(0, 255));
      pt = 2'($urandom_range(0, 3));
      pt_a = pt;
      exp_q.push_back({pt, d});
      push(d, wcyc);
      fork
        expect_frame(wcyc + 2, 8, 1, ts, nb);
        begin
          repeat (15) @(negedge clk);
          pt_a = 2'($urandom_range(0, 3));
        end
      join
    end

    // Depth-4 buffer: six writes in consecutive cycles, sixth dropped.
    pt_a = 2'd2;
    @(negedge clk);
    base = cyc;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          if (i > 0) @(negedge clk);
          if (i == 5) begin
            check_val("wr_ready_full", int'(wr_a), 0);
            check_val("count_full", int'(cnt_a), 4);
          end
          d = 9'($urandom_range(0, 255));
          if (i < 5) exp_q.push_back({2'd2, d});
          wd_a = d[7:0];
          wv_a = 1'b1;
        end
        @(negedge clk);
        wv_a = 1'b0;
        check_val("count_after_drop", int'(cnt_a), 4);
      end
      begin
        ts = base + 2;
        for (int j = 0; j < 5; j++) begin
          expect_frame(ts, 8, 1, ts, nb);
          ts = ts + nb * CPB + 1;
        end
      end
    join
    check_val("fifo_drained", int'(cnt_a), 0);

    // DUT B: 7 data bits, 2 stop bits.
    sel_b = 1'b1;
    pt_b = 2'd0;
    exp_q.push_back({2'd0, 9'h055});
    push(9'h055, wcyc);
    expect_frame(wcyc + 2, 7, 2, ts, nb);
    check_val("b_frame_bits", nb, 10);
    d = 9'($urandom_range(0, 127));
    pt_b = 2'd2;
    exp_q.push_back({2'd2, d});
    push(d, wcyc);
    expect_frame(wcyc + 2, 7, 2, ts, nb);
    sel_b = 1'b0;

    // Reset in the middle of a data bit with three words still queued.
    pt_a = 2'd0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      wd_a = 8'($urandom_range(0, 255));
      wv_a = 1'b1;
    end
    @(negedge clk);
    wv_a = 1'b0;
    repeat (30) @(negedge clk);
    check_val("pre_rst_count", int'(cnt_a), 3);
    check_val("pre_rst_state", int'(st_a), int'(DATA));
    #2 rst = 1'b0;
    #1;
    check_val("mid_rst_serial_out", int'(so_a), 1);
    check_val("mid_rst_busy", int'(busy_a), 0);
    check_val("mid_rst_count", int'(cnt_a), 0);
    check_val("mid_rst_wr_ready", int'(wr_a), 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    low_n = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (!so_a || busy_a) low_n++;
    end
    check_val("no_tx_after_rst", low_n, 0);

`ifdef UART_TX_BREAK_EN
    // One-cycle break request, then a word queued during the break.
    pt_a = 2'd2;
    @(negedge clk);
    brk_a = 1'b1;
    @(negedge clk);
    brk_a = 1'b0;
    low_n = (so_a == 1'b0) ? 1 : 0;
    d = 9'($urandom_range(0, 255));
    exp_q.push_back({2'd2, d});
    wd_a = d[7:0];
    wv_a = 1'b1;
    @(negedge clk);
    wv_a = 1'b0;
    if (!so_a) low_n++;
    check_val("no_pop_in_break", int'(cnt_a), 1);
    for (int g = 0; g < 1000; g++) begin
      @(negedge clk);
      if (so_a) break;
      low_n++;
    end
    check_val("break_len_ge_110", (low_n >= 110) ? 1 : 0, 1);
    expect_frame(-1, 8, 1, ts, nb);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_buffered.md
UART_TX_BUFFERED -- requirements
Module: uart_tx_buffered

Interface
REQ-001 SHALL provide parameter CLK_FREQ, default 50_000_000, meaning system clock frequency in Hz.
REQ-002 SHALL provide parameter BAUD, default 115_200, meaning line bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD, integer-truncated, minimum 2.
REQ-003 SHALL provide parameter DATA_BITS, default 8, meaning frame payload width; legal range 5..9.
REQ-004 SHALL provide parameter STOP_BITS, default 1, meaning stop-bit count; legal values 1 or 2.
REQ-005 SHALL provide parameter FIFO_DEPTH, default 16, meaning transmit buffer entries; power of two, at least 2.
REQ-006 SHALL provide port clk  input  1  system clock, all logic on rising edge.
REQ-007 SHALL provide port rst  input  1  asynchronous, active-low reset.
REQ-008 SHALL provide port wr_data  input  DATA_BITS  word to enqueue.
REQ-009 SHALL provide port wr_valid  input  1  enqueue request.
REQ-010 SHALL provide port wr_ready  output  1  high when FIFO not full.
REQ-011 SHALL provide port parity_type  input  2  0 = none, 1 = odd, 2 = even, 3 = none.
REQ-012 SHALL provide port serial_out  output  1  TX line, idle high.
REQ-013 SHALL provide port busy  output  1  high outside IDLE state.
REQ-014 SHALL provide port fifo_count  output  $clog2(FIFO_DEPTH)+1  number of buffered words.

Function
REQ-015 SHALL accept a write on any cycle where wr_valid && wr_ready; writes while full are dropped with no state change.
REQ-016 SHALL compute wr_ready = !full from registered count, so a simultaneous pop does not admit a write into a full FIFO.
REQ-017 SHALL use FSM states IDLE, START, DATA, PARITY, STOP.
REQ-018 SHALL, in IDLE with fifo_count > 0 at cycle N, pop one word, latch it and parity_type, and enter START; serial_out goes low from cycle N+1.
REQ-019 SHALL hold each bit for exactly CLKS_PER_BIT cycles, timed by a bit counter cleared on every state entry.
REQ-020 SHALL transmit DATA bits LSB first, DATA_BITS bits.
REQ-021 SHALL enter PARITY only when the latched parity_type is 1 or 2: odd gives bit = ~^data, even gives bit = ^data; otherwise go DATA -> STOP.
REQ-022 SHALL drive STOP high for STOP_BITS*CLKS_PER_BIT cycles, then return to IDLE.
REQ-023 SHALL allow back-to-back frames: if the FIFO is non-empty at IDLE entry, the next start bit begins one cycle after the stop period.
REQ-024 SHALL ignore parity_type changes mid-frame.
REQ-025 SHALL let a write to an empty FIFO be popped no earlier than the following cycle.

Reset
REQ-026 SHALL on rst low, immediately force serial_out = 1, busy = 0, wr_ready = 1, fifo_count = 0, FSM = IDLE, counters = 0.
REQ-027 SHALL abort any in-flight frame on reset and discard FIFO contents; no partial frame resumes after release.

Configuration
REQ-028 SHALL, with UART_TX_BREAK_EN defined, add input send_break (1 bit): when asserted in IDLE, drive serial_out low while asserted plus at least one full frame time, then return to IDLE; the FIFO is not popped during break.
REQ-029 SHALL, without UART_TX_BREAK_EN, have no send_break port and no break logic.

Structure
REQ-030 SHALL place the parity encodings (PAR_NONE, PAR_ODD, PAR_EVEN) and the FSM state typedef in shared package uart_pkg.
REQ-031 SHALL implement the buffer as sub-module sync_fifo (parameters WIDTH, DEPTH; wrap-around pointers with an extra MSB for full/empty).

Verification
REQ-032 SHALL cover: CLK_FREQ=50e6, BAUD=5e6, parity_type=2, write 8'hD2 -> line 0,0,1,0,0,1,0,1,1,0,1 with 10 clocks per bit, busy for 110 clocks.
REQ-033 SHALL cover: same setup with parity_type=1 -> parity bit 1; parity_type=0 -> 10-bit frame with no parity bit.
REQ-034 SHALL cover: FIFO_DEPTH=4, write 6 words in consecutive cycles while IDLE -> first popped, 4 buffered, 6th dropped with wr_ready low; 5 frames sent back-to-back.
REQ-035 SHALL cover: STOP_BITS=2, DATA_BITS=7, write 7'h55 -> stop high for 20 clocks; frame length 100 clocks with parity none.
REQ-036 SHALL cover: rst low mid-DATA with 3 words queued -> serial_out high same cycle, fifo_count 0, no transmission after release.
REQ-037 SHALL cover: with UART_TX_BREAK_EN, send_break pulsed for 1 cycle in IDLE -> line low for at least 110 clocks, queued word sent afterwards.
